// File: rtl/bsg_link_sdr_vc_pkg.sv
// Shared constants and helpers for the SDR virtual-channel link upstream.
//   stat_width_lp : width of each per-VC sent-word counter
//   vc_id_width() : width of a VC id, never less than one bit
package bsg_link_sdr_vc_pkg;

  localparam int stat_width_lp = 32;

  function automatic int vc_id_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/bsg_link_sdr_vc_upstream_if.sv
// Bundle of the core-side and link-side signals of the VC upstream.
//   master : drives core valid/data and link tokens, observes the rest
//   slave  : the upstream block's view (accepts core words, drives link)
//
// Handshake: core_v[i] offers core_data slice i; the word is taken in the
// cycle core_yumi[i]=1 (yumi depends combinationally on core_v). link_v
// has no back-pressure; flow control is by per-VC link_token pulses.
interface bsg_link_sdr_vc_upstream_if
  import bsg_link_sdr_vc_pkg::*;
#(
  parameter int width_p    = 32,
  parameter int channels_p = 2,
  parameter int vc_w_p     = vc_id_width(channels_p)
);
  logic [channels_p-1:0]               core_v;
  logic [channels_p*width_p-1:0]       core_data;
  logic [channels_p-1:0]               core_yumi;
  logic                                link_v;
  logic [width_p-1:0]                  link_data;
  logic [vc_w_p-1:0]                   link_vc;
  logic [channels_p-1:0]               link_token;
  logic [channels_p*stat_width_lp-1:0] stat_sent;

  modport master (
    output core_v, core_data, link_token,
    input  core_yumi, link_v, link_data, link_vc, stat_sent
  );

  modport slave (
    input  core_v, core_data, link_token,
    output core_yumi, link_v, link_data, link_vc, stat_sent
  );
endinterface

// File: rtl/bsg_link_sdr_vc_credit_counter.sv
// One per-VC credit counter.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   grant_i        : a word for this VC was accepted this cycle (-1 credit)
//   token_i        : token pulse from the receiver (+2^decimation credits)
//   avail_o        : credit is non-zero, so the VC may be granted
// Resets to a full buffer's worth of credit (2^lg_fifo_depth_p).
module bsg_link_sdr_vc_credit_counter #(
  parameter int lg_fifo_depth_p                 = 3,
  parameter int lg_credit_to_token_decimation_p = 0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic grant_i,
  input  logic token_i,
  output logic avail_o
);

  localparam int cw_lp = lg_fifo_depth_p + 1;
  // One spare bit so an over-return is visible before saturation.
  localparam int sw_lp = cw_lp + 1;
  localparam logic [sw_lp-1:0] max_lp = sw_lp'(1) << lg_fifo_depth_p;
  localparam logic [sw_lp-1:0] inc_lp = sw_lp'(1) << lg_credit_to_token_decimation_p;

  logic [cw_lp-1:0] credit_q, credit_d;
  logic [sw_lp-1:0] sum;
  logic             overflow;

  // Grant never happens at zero credit, so the subtraction cannot wrap.
  always_comb begin
    sum = {1'b0, credit_q};
    if (token_i) sum = sum + inc_lp;
    if (grant_i) sum = sum - sw_lp'(1);
    overflow = (sum > max_lp);
    credit_d = overflow ? max_lp[cw_lp-1:0] : sum[cw_lp-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) credit_q <= max_lp[cw_lp-1:0];
    else          credit_q <= credit_d;
  end

  assign avail_o = (credit_q != '0);

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (!overflow)
        else $error("credit counter: token returned more credit than the receiver buffer holds");
    end
  end
`endif

endmodule

// File: rtl/bsg_link_sdr_vc_upstream.sv
// Credit-based virtual-channel multiplexer onto a single SDR link.
//   core_clk_i, core_reset_n_i : clock, asynchronous active-low reset
//   core_v_i / core_data_i     : per-VC offered words (VC i at [i*width_p +: width_p])
//   core_yumi_o                : one-hot-or-zero accept, combinational
//   link_v_o / link_data_o / link_vc_o : registered link word, 1-cycle latency
//   link_token_i               : per-VC credit return pulses (synchronous)
//   stat_sent_o                : per-VC sent-word counters
// Optional feature: define BSG_LINK_SDR_VC_STATS_EN to build the sent-word
// counters; otherwise stat_sent_o is constant zero.
module bsg_link_sdr_vc_upstream
  import bsg_link_sdr_vc_pkg::*;
#(
  parameter int width_p                         = 32,
  parameter int channels_p                      = 2,
  parameter int lg_fifo_depth_p                 = 3,
  parameter int lg_credit_to_token_decimation_p = 0
) (
  input  logic                                core_clk_i,
  input  logic                                core_reset_n_i,
  input  logic [channels_p-1:0]               core_v_i,
  input  logic [channels_p*width_p-1:0]       core_data_i,
  output logic [channels_p-1:0]               core_yumi_o,
  output logic                                link_v_o,
  output logic [width_p-1:0]                  link_data_o,
  output logic [vc_id_width(channels_p)-1:0]  link_vc_o,
  input  logic [channels_p-1:0]               link_token_i,
  output logic [channels_p*stat_width_lp-1:0] stat_sent_o
);

  localparam int vc_w_lp = vc_id_width(channels_p);

  logic [channels_p-1:0] credit_avail;
  logic [channels_p-1:0] eligible;
  logic [channels_p-1:0] grant_vec;
  logic                  any_grant;
  logic [vc_w_lp-1:0]    grant_id;
  logic [vc_w_lp-1:0]    idx;

  logic [vc_w_lp-1:0]    last_q, last_d;
  logic                  link_v_q, link_v_d;
  logic [width_p-1:0]    link_data_q, link_data_d;
  logic [vc_w_lp-1:0]    link_vc_q, link_vc_d;

  for (genvar i = 0; i < channels_p; i++) begin : g_credit
    bsg_link_sdr_vc_credit_counter #(
      .lg_fifo_depth_p                (lg_fifo_depth_p),
      .lg_credit_to_token_decimation_p(lg_credit_to_token_decimation_p)
    ) u_credit (
      .clk_i  (core_clk_i),
      .rst_n_i(core_reset_n_i),
      .grant_i(grant_vec[i]),
      .token_i(link_token_i[i]),
      .avail_o(credit_avail[i])
    );
  end

  // Reset gates eligibility so no word is accepted while reset is held.
  assign eligible = core_v_i & credit_avail & {channels_p{core_reset_n_i}};

  // Round-robin: scan from last_q+1 upward, wrapping, first eligible wins.
  always_comb begin
    grant_vec = '0;
    grant_id  = last_q;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 1; k <= channels_p; k++) begin
      idx = vc_w_lp'((int'(last_q) + k) % channels_p);
      if (!any_grant && eligible[idx]) begin
        any_grant      = 1'b1;
        grant_id       = idx;
        grant_vec[idx] = 1'b1;
      end
    end
  end

  assign core_yumi_o = grant_vec;

  always_comb begin
    last_d      = any_grant ? grant_id : last_q;
    link_v_d    = any_grant;
    link_data_d = any_grant ? core_data_i[int'(grant_id)*width_p +: width_p] : link_data_q;
    link_vc_d   = any_grant ? grant_id : link_vc_q;
  end

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      last_q      <= vc_w_lp'(channels_p - 1);
      link_v_q    <= 1'b0;
      link_data_q <= '0;
      link_vc_q   <= '0;
    end else begin
      last_q      <= last_d;
      link_v_q    <= link_v_d;
      link_data_q <= link_data_d;
      link_vc_q   <= link_vc_d;
    end
  end

  assign link_v_o    = link_v_q;
  assign link_data_o = link_data_q;
  assign link_vc_o   = link_vc_q;

`ifdef BSG_LINK_SDR_VC_STATS_EN
  logic [stat_width_lp-1:0] stat_q [channels_p];
  logic [stat_width_lp-1:0] stat_d [channels_p];

  always_comb begin
    for (int i = 0; i < channels_p; i++) begin
      stat_d[i] = stat_q[i] + stat_width_lp'(grant_vec[i]);
    end
  end

  always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      for (int i = 0; i < channels_p; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < channels_p; i++) stat_q[i] <= stat_d[i];
    end
  end

  for (genvar i = 0; i < channels_p; i++) begin : g_stat
    assign stat_sent_o[i*stat_width_lp +: stat_width_lp] = stat_q[i];
  end
`else
  assign stat_sent_o = '0;
`endif

endmodule

// File: tb/tb_bsg_link_sdr_vc_upstream.sv
module tb_bsg_link_sdr_vc_upstream;
  import bsg_link_sdr_vc_pkg::*;

  localparam int W    = 32;
  localparam int CH   = 2;
  localparam int LG   = 3;
  localparam int MAXC = 1 << LG;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a: decimation 0; instance b: decimation 2.
  bsg_link_sdr_vc_upstream_if #(.width_p(W), .channels_p(CH)) bus_a ();
  bsg_link_sdr_vc_upstream_if #(.width_p(W), .channels_p(CH)) bus_b ();

  bsg_link_sdr_vc_upstream #(
    .width_p(W), .channels_p(CH), .lg_fifo_depth_p(LG), .lg_credit_to_token_decimation_p(0)
  ) dut_a (
    .core_clk_i(clk), .core_reset_n_i(rst_n),
    .core_v_i(bus_a.core_v), .core_data_i(bus_a.core_data), .core_yumi_o(bus_a.core_yumi),
    .link_v_o(bus_a.link_v), .link_data_o(bus_a.link_data), .link_vc_o(bus_a.link_vc),
    .link_token_i(bus_a.link_token), .stat_sent_o(bus_a.stat_sent)
  );

  bsg_link_sdr_vc_upstream #(
    .width_p(W), .channels_p(CH), .lg_fifo_depth_p(LG), .lg_credit_to_token_decimation_p(2)
  ) dut_b (
    .core_clk_i(clk), .core_reset_n_i(rst_n),
    .core_v_i(bus_b.core_v), .core_data_i(bus_b.core_data), .core_yumi_o(bus_b.core_yumi),
    .link_v_o(bus_b.link_v), .link_data_o(bus_b.link_data), .link_vc_o(bus_b.link_vc),
    .link_token_i(bus_b.link_token), .stat_sent_o(bus_b.stat_sent)
  );

  // ---------------- reference model ----------------
  int          m_credit [2][CH];
  int          m_last   [2];
  logic        m_lv     [2];
  logic [W-1:0] m_ld    [2];
  int          m_lvc    [2];
  logic [31:0] m_stat   [2][CH];
  int          n_yumi   [2][CH];
  logic        last_lv  [2];
  int          lvc_hist_a [$];

  function automatic int dec_of(input int u);
    return (u == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_last[u] = CH - 1;
      m_lv[u]   = 1'b0;
      m_ld[u]   = '0;
      m_lvc[u]  = 0;
      for (int i = 0; i < CH; i++) begin
        m_credit[u][i] = MAXC;
        m_stat[u][i]   = '0;
      end
    end
  endtask

  task automatic clear_counts();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < CH; i++) n_yumi[u][i] = 0;
    lvc_hist_a.delete();
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic [CH-1:0] va, input logic [CH-1:0] ta,
                       input logic [CH-1:0] vb, input logic [CH-1:0] tkb);
    logic [CH-1:0]   v [2];
    logic [CH-1:0]   t [2];
    logic [CH*W-1:0] d [2];
    int              win [2];
    logic [CH-1:0]   o_yumi;
    logic            o_lv;
    logic [W-1:0]    o_ld;
    logic            o_lvc;
    logic [CH*32-1:0] o_st;
    v[0] = va; v[1] = vb; t[0] = ta; t[1] = tkb;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < CH; i++) d[u][i*W +: W] = $urandom;
      win[u] = -1;
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_last[u] + k) % CH;
        if (win[u] < 0 && v[u][c] && m_credit[u][c] > 0) win[u] = c;
      end
      // Never return more credit than the receiver could have freed.
      for (int i = 0; i < CH; i++)
        if (t[u][i] && (m_credit[u][i] - ((win[u] == i) ? 1 : 0) + (1 << dec_of(u)) > MAXC))
          t[u][i] = 1'b0;
    end
    bus_a.core_v = v[0]; bus_a.core_data = d[0]; bus_a.link_token = t[0];
    bus_b.core_v = v[1]; bus_b.core_data = d[1]; bus_b.link_token = t[1];
    #1;
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin
        o_yumi = bus_a.core_yumi; o_lv = bus_a.link_v; o_ld = bus_a.link_data;
        o_lvc = bus_a.link_vc; o_st = bus_a.stat_sent;
      end else begin
        o_yumi = bus_b.core_yumi; o_lv = bus_b.link_v; o_ld = bus_b.link_data;
        o_lvc = bus_b.link_vc; o_st = bus_b.stat_sent;
      end
      chk($sformatf("yumi_u%0d", u), 64'(o_yumi), (win[u] >= 0) ? (64'd1 << win[u]) : 64'd0);
      chk($sformatf("link_v_u%0d", u), 64'(o_lv), 64'(m_lv[u]));
      chk($sformatf("link_data_u%0d", u), 64'(o_ld), 64'(m_ld[u]));
      chk($sformatf("link_vc_u%0d", u), 64'(o_lvc), 64'(m_lvc[u]));
      for (int i = 0; i < CH; i++) begin
`ifdef BSG_LINK_SDR_VC_STATS_EN
        chk($sformatf("stat_u%0d_vc%0d", u, i), 64'(o_st[i*32 +: 32]), 64'(m_stat[u][i]));
`else
        chk($sformatf("stat_u%0d_vc%0d", u, i), 64'(o_st[i*32 +: 32]), 64'd0);
`endif
        n_yumi[u][i] += int'(o_yumi[i]);
      end
      last_lv[u] = o_lv;
      if (u == 0 && o_lv) lvc_hist_a.push_back(int'(o_lvc));
      // advance the model across the coming edge
      if (win[u] >= 0) begin
        m_credit[u][win[u]] -= 1;
        m_last[u]            = win[u];
        m_lv[u]              = 1'b1;
        m_ld[u]              = d[u][win[u]*W +: W];
        m_lvc[u]             = win[u];
        m_stat[u][win[u]]    = m_stat[u][win[u]] + 32'd1;
      end else begin
        m_lv[u] = 1'b0;
      end
      for (int i = 0; i < CH; i++)
        if (t[u][i]) m_credit[u][i] += (1 << dec_of(u));
    end
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus_a.core_v = '1; bus_a.link_token = '0;
    bus_b.core_v = '1; bus_b.link_token = '0;
    #1;
    chk("rst_link_v_a", 64'(bus_a.link_v), 64'd0);
    chk("rst_link_data_a", 64'(bus_a.link_data), 64'd0);
    chk("rst_link_vc_a", 64'(bus_a.link_vc), 64'd0);
    chk("rst_yumi_a", 64'(bus_a.core_yumi), 64'd0);
    chk("rst_stat_a", 64'(bus_a.stat_sent), 64'd0);
    chk("rst_link_v_b", 64'(bus_b.link_v), 64'd0);
    chk("rst_yumi_b", 64'(bus_b.core_yumi), 64'd0);
    chk("rst_stat_b", 64'(bus_b.stat_sent), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.core_v = '0;
    bus_b.core_v = '0;
    model_reset();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus_a.core_v = '0; bus_a.core_data = '0; bus_a.link_token = '0;
    bus_b.core_v = '0; bus_b.core_data = '0; bus_b.link_token = '0;
    model_reset();
    do_reset();

    // VC0 alone, no tokens: eight back-to-back accepts then silence.
    clear_counts();
    repeat (10) cycle(2'b01, 2'b00, 2'b00, 2'b00);
    chk("drain8_vc0_yumis", 64'(n_yumi[0][0]), 64'd8);
    chk("drain8_link_v_cycle10", 64'(last_lv[0]), 64'd0);

    // Both VCs valid: link_vc alternates starting at VC0.
    do_reset();
    clear_counts();
    repeat (5) cycle(2'b11, 2'b00, 2'b00, 2'b00);
    chk("alt_count", 64'(lvc_hist_a.size()), 64'd4);
    for (int j = 0; j < 4 && j < lvc_hist_a.size(); j++)
      chk($sformatf("alt_vc_%0d", j), 64'(lvc_hist_a[j]), 64'(j % 2));

    // Grant and token together at credit 5 leave credit at 5.
    do_reset();
    repeat (3) cycle(2'b01, 2'b00, 2'b00, 2'b00);
    cycle(2'b01, 2'b01, 2'b00, 2'b00);
    clear_counts();
    repeat (8) cycle(2'b01, 2'b00, 2'b00, 2'b00);
    chk("same_cycle_credit5_drain", 64'(n_yumi[0][0]), 64'd5);

    // Decimation 2: token at zero credit is not usable that cycle, then 4 grants.
    do_reset();
    repeat (8) cycle(2'b00, 2'b00, 2'b10, 2'b00);
    clear_counts();
    cycle(2'b00, 2'b00, 2'b10, 2'b10);
    chk("dec2_token_cycle_no_grant", 64'(n_yumi[1][1]), 64'd0);
    repeat (6) cycle(2'b00, 2'b00, 2'b10, 2'b00);
    chk("dec2_four_grants", 64'(n_yumi[1][1]), 64'd4);

    // Random traffic with credit returns on both instances.
    do_reset();
    for (int n = 0; n < 400; n++)
      cycle(CH'($urandom), CH'($urandom), CH'($urandom), CH'($urandom));

    // Mid-stream reset: drop the in-flight word, credits back to full.
    cycle(2'b11, 2'b00, 2'b11, 2'b00);
    @(negedge clk);
    #1;
    chk("pre_reset_link_v", 64'(bus_a.link_v), 64'd1);
    do_reset();
    clear_counts();
    repeat (10) cycle(2'b01, 2'b00, 2'b01, 2'b00);
    chk("post_reset_credit_a", 64'(n_yumi[0][0]), 64'd8);
    chk("post_reset_credit_b", 64'(n_yumi[1][0]), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
